// File: rtl/knn_vote_if.sv
// Handshake/bus bundle between the top-K tracker, the vote unit and the result consumer.
// master drives the neighbour list, start and result_ready; slave is the vote unit.
interface knn_vote_if #(
    parameter int K       = 5,
    parameter int DIST_W  = 32,
    parameter int LABEL_W = 2,
    parameter int CNT_W   = 3
);
    logic                 start;
    logic [K*DIST_W-1:0]  top_dist;
    logic [K*LABEL_W-1:0] top_label;
    logic [K-1:0]         top_valid;
    logic                 busy;
    logic                 result_valid;
    logic                 result_ready;
    logic [LABEL_W-1:0]   class_out;
    logic [CNT_W-1:0]     vote_count;
    logic [DIST_W-1:0]    nearest_dist;
    logic                 empty;

    modport master (
        output start, top_dist, top_label, top_valid, result_ready,
        input  busy, result_valid, class_out, vote_count, nearest_dist, empty
    );

    modport slave (
        input  start, top_dist, top_label, top_valid, result_ready,
        output busy, result_valid, class_out, vote_count, nearest_dist, empty
    );
endinterface

// File: rtl/knn_vote.sv
// k-NN majority vote: snapshots the top-K list, scans one entry per cycle, then picks the
// class with the most votes (ties broken by nearest distance, then lowest index).
module knn_vote #(
    parameter int K           = 5,
    parameter int NUM_CLASSES = 4,
    parameter int DIST_W      = 32,
    parameter int LABEL_W     = 2,
    parameter int CNT_W       = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    knn_vote_if.slave   bus
);
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DECIDE, HOLD} state_t;

    state_t               state_q;
    logic [K*DIST_W-1:0]  snap_dist_q;
    logic [K*LABEL_W-1:0] snap_label_q;
    logic [K-1:0]         snap_valid_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CLS_W-1:0]     cls_q;
    logic [CNT_W-1:0]     votes_q [NUM_CLASSES];
    logic [DIST_W-1:0]    near_q  [NUM_CLASSES];
    logic [CNT_W-1:0]     best_votes_q, best_votes_d;
    logic [DIST_W-1:0]    best_near_q, best_near_d;
    logic [LABEL_W-1:0]   best_cls_q, best_cls_d;
    logic                 busy_q, result_valid_q, empty_q;
    logic [LABEL_W-1:0]   class_q;
    logic [CNT_W-1:0]     vote_q;
    logic [DIST_W-1:0]    nearest_q;

    // Snapshot is shifted down each SCAN cycle, so the current entry is always slot 0.
    logic [DIST_W-1:0]  cur_dist;
    logic [LABEL_W-1:0] cur_label;
    logic               counted;
    logic               take;

    assign cur_dist  = snap_dist_q[DIST_W-1:0];
    assign cur_label = snap_label_q[LABEL_W-1:0];
    assign counted   = snap_valid_q[0] && ({1'b0, cur_label} < (LABEL_W+1)'(NUM_CLASSES));

    always_comb begin
        take = 1'b0;
        if (votes_q[cls_q] > best_votes_q) begin
            take = 1'b1;
        end else if (votes_q[cls_q] == best_votes_q && near_q[cls_q] < best_near_q) begin
            take = 1'b1;
        end
        best_votes_d = take ? votes_q[cls_q]    : best_votes_q;
        best_near_d  = take ? near_q[cls_q]     : best_near_q;
        best_cls_d   = take ? LABEL_W'(cls_q)   : best_cls_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            snap_dist_q    <= '0;
            snap_label_q   <= '0;
            snap_valid_q   <= '0;
            idx_q          <= '0;
            cls_q          <= '0;
            best_votes_q   <= '0;
            best_near_q    <= '0;
            best_cls_q     <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            empty_q        <= 1'b0;
            class_q        <= '0;
            vote_q         <= '0;
            nearest_q      <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                votes_q[c] <= '0;
                near_q[c]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        snap_dist_q  <= bus.top_dist;
                        snap_label_q <= bus.top_label;
                        snap_valid_q <= bus.top_valid;
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            votes_q[c] <= '0;
                            near_q[c]  <= '1;
                        end
                        idx_q        <= '0;
                        best_votes_q <= '0;
                        best_near_q  <= '1;
                        best_cls_q   <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= SCAN;
                    end
                end
                SCAN: begin
                    if (counted) begin
                        votes_q[cur_label] <= votes_q[cur_label] + 1'b1;
                        if (cur_dist < near_q[cur_label]) begin
                            near_q[cur_label] <= cur_dist;
                        end
                    end
                    snap_dist_q  <= snap_dist_q >> DIST_W;
                    snap_label_q <= snap_label_q >> LABEL_W;
                    snap_valid_q <= snap_valid_q >> 1;
                    idx_q        <= idx_q + 1'b1;
                    if (idx_q == IDX_W'(K - 1)) begin
                        cls_q   <= '0;
                        state_q <= DECIDE;
                    end
                end
                DECIDE: begin
                    best_votes_q <= best_votes_d;
                    best_near_q  <= best_near_d;
                    best_cls_q   <= best_cls_d;
                    cls_q        <= cls_q + 1'b1;
                    // With zero votes nothing can displace the initial best, so the
                    // empty result (class 0, count 0, all-ones distance) falls out naturally.
                    if (cls_q == CLS_W'(NUM_CLASSES - 1)) begin
                        class_q        <= best_cls_d;
                        vote_q         <= best_votes_d;
                        nearest_q      <= best_near_d;
                        empty_q        <= (best_votes_d == '0);
                        result_valid_q <= 1'b1;
                        state_q        <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.class_out    = class_q;
    assign bus.vote_count   = vote_q;
    assign bus.nearest_dist = nearest_q;
    assign bus.empty        = empty_q;
endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Consumer side of the top-K distance list. Takes a snapshot of the K nearest-neighbour entries (distance, label, valid) and scans them sequentially.
- Tallies per-class votes and tracks the nearest distance per class, then resolves the winning class and holds it behind a valid/ready handshake.
- Sits between the top-K tracking logic and the classifier result register.

Parameters:
- K, 5, number of top-K entries scanned.
- NUM_CLASSES, 4, number of class labels; legal labels are 0..NUM_CLASSES-1.
- DIST_W, 32, distance width.
- LABEL_W, 2, label width; must satisfy 2**LABEL_W >= NUM_CLASSES.
- CNT_W, 3, vote counter width; must satisfy 2**CNT_W > K.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a vote; sampled in IDLE only.
- top_dist  in  K*DIST_W  entry i occupies bits [i*DIST_W +: DIST_W].
- top_label  in  K*LABEL_W  entry i label.
- top_valid  in  K  entry i holds a real neighbour.
- busy  out  1  high in SCAN, DECIDE and HOLD.
- result_valid  out  1  result available.
- result_ready  in  1  downstream accepts result.
- class_out  out  LABEL_W  winning class.
- vote_count  out  CNT_W  votes for the winning class.
- nearest_dist  out  DIST_W  smallest distance among winning-class entries.
- empty  out  1  no valid, in-range entry was scanned.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0; snapshot, counters, per-class registers 0. Applies at any point, including mid-SCAN or mid-HOLD.
- IDLE: busy=0. If start=1 at edge t:
  - capture top_dist, top_label, top_valid into snapshot registers; later input changes have no effect on this vote;
  - clear votes[c]=0 and near[c]=all-ones for every class;
  - index=0; go to SCAN.
- SCAN: one entry per cycle, index 0..K-1. An entry counts only if valid and label<NUM_CLASSES; out-of-range labels are silently dropped. A counted entry does:
  - votes[label] += 1;
  - near[label] = min(near[label], dist).
  - After index K-1, go to DECIDE with cls=0.
- DECIDE: one class per cycle, c=0..NUM_CLASSES-1. Class c replaces the current best if either:
  - votes[c] > best_votes; or
  - votes[c] == best_votes and near[c] < best_near.
  - Equal on both keeps the earlier (lower-index) class.
  - Initial best before c=0: votes=0, near=all-ones, class=0.
  - After the last class, go to HOLD.
- HOLD outputs:
  - result_valid=1; class_out, vote_count, nearest_dist from the best register.
  - empty=1 iff best_votes==0; in that case class_out=0, vote_count=0, nearest_dist=all-ones.
- Latency: start sampled at edge t; result_valid rises after edge t+K+NUM_CLASSES (9 cycles for the defaults).
- Handshake:
  - outputs stay stable while result_valid=1 and result_ready=0;
  - on an edge with result_valid=1 and result_ready=1, go to IDLE and drop result_valid and busy the next cycle;
  - class_out, vote_count, nearest_dist and empty hold their values until the next HOLD or reset.
- start outside IDLE is ignored, including a start in the same cycle as the HOLD handshake; the requester re-asserts start once busy=0.
- Arithmetic:
  - vote counters saturate-free; CNT_W guarantees no overflow;
  - distance compares are unsigned;
  - an all-ones distance from a valid entry counts as a vote but does not lower near.

Test Plan:
1. K=5, C=4; labels {2,2,1,3,2}, dists {10,20,5,7,30}, all valid; start at t -> result_valid rises 9 cycles later; class_out=2, vote_count=3, nearest_dist=10, empty=0.
2. Labels {1,1,3,3,0}, dists {50,40,9,60,100}, all valid -> classes 1 and 3 tie at 2 votes; nearest 40 vs 9; class_out=3, vote_count=2, nearest_dist=9.
3. Labels {0,2,0,2,1}, dists {8,20,20,8,5}, top_valid=5'b01111 -> 0 and 2 tie on votes (2) and nearest (8); class_out=0, vote_count=2, nearest_dist=8.
4. Out-of-range and empty cases:
   - top_valid=0 -> empty=1, class_out=0, vote_count=0, nearest_dist=32'hFFFFFFFF.
   - With NUM_CLASSES=3, labels {3,3,3,1,1}, all valid -> label-3 entries dropped; class_out=1, vote_count=2.
5. Backpressure and snapshot:
   - hold result_ready=0 for 6 cycles -> outputs constant, busy=1;
   - pulse start mid-SCAN and during HOLD -> ignored;
   - change top_* one cycle after start -> result matches the first snapshot.
6. Reset and recovery:
   - assert rst_n=0 asynchronously on the third SCAN cycle -> busy, result_valid, class_out drop to 0 without a clock edge;
   - release and start scenario 1 -> correct result after 9 cycles.
